timer_counter: RTL

Programmable down-counting timer that is the interrupt source side of the exception path. Software programs it with store/load accesses through the bridge. Its `IRQ` output feeds the interrupt input that CP0 samples and qualifies against `SR`. It supports one-shot and auto-reload modes, with a level or single-cycle interrupt request gated by a software mask.

---
 rtl/timer_counter.sv | 86 ++++++++
 1 files changed

// File: rtl/timer_counter.sv
// timer_counter: programmable down-counting timer, interrupt source for CP0.
// One-shot / auto-reload modes with a masked level or pulse IRQ.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        IRQ
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [1:0]  state;
  logic        irq_flag;
  logic        sw_wr;
  logic        reload;

  assign sw_wr  = WE && (Addr == 2'd0 || Addr == 2'd1);
  assign reload = (ctrl[2:1] == 2'b01);
  assign IRQ    = ctrl[3] & irq_flag;

  // Register writes win over any FSM action on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      state    <= IDLE;
      irq_flag <= 1'b0;
    end else if (sw_wr) begin
      if (Addr == 2'd0) ctrl <= DataIn[3:0];
      else              preset <= DataIn;
      state    <= IDLE;
      irq_flag <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctrl[0]) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl[0]) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= 32'd0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          if (reload) begin
            irq_flag <= 1'b0;
          end else begin
            ctrl[0] <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    DataOut = 32'd0;
    case (Addr)
      2'd0:    DataOut = {28'd0, ctrl};
      2'd1:    DataOut = preset;
      2'd2:    DataOut = count;
      default: DataOut = 32'd0;
    endcase
  end

endmodule
